acumulador_digitos: RTL and testbench

Collects debounced key codes from the 4x4 keypad decoder into a BCD digit buffer, closing an entry on `#` and handing the completed number downstream as a single-cycle strobe. Sits directly after the keypad decoder (consumes `tecla_value`/`tecla_valid`) and before the access/password comparison logic. Provides clear, optional backspace and an inactivity timeout that discards half-typed entries.

---
 rtl/acumulador_digitos.sv | 193 +++++++++++++++++++
 tb/tb_acumulador_digitos.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_digitos.sv
`default_nettype none
// ============================================================================
//  Module   : acumulador_digitos
//  Purpose  : Collects debounced keypad codes into a BCD digit buffer. `#`
//             closes the entry and hands it downstream with a one-cycle
//             strobe. `A` clears the buffer, `*` optionally deletes the
//             newest digit, and an inactivity timeout discards a partly
//             typed entry.
//  Revision : 1.0 - initial release
//
//  Parameters
//    MAX_DIGITOS  buffer capacity in digits (1..8)
//    TIMEOUT_P    idle cycles after the last accepted key before a non-empty
//                 entry is discarded (>= 2)
//
//  Ports
//    clk           in   system clock, rising edge
//    rst           in   synchronous active-high reset
//    tecla_value   in   key code, sampled on a tecla_valid rising edge
//    tecla_valid   in   level, high while a debounced key is held
//    digitos       out  live BCD buffer, newest digit in nibble 0
//    num_digitos   out  digits currently buffered
//    buffer_cheio  out  high while the buffer is full
//    senha         out  last closed entry
//    senha_tam     out  digit count of senha
//    dado_valid    out  one-cycle pulse when senha/senha_tam update
//    timeout       out  one-cycle pulse when an entry is discarded by idling
//
//  Build option
//    ACUMULADOR_BACKSPACE_EN : when defined, key 0xE deletes the newest digit;
//                              otherwise 0xE is ignored like 0xB..0xD.
// ============================================================================
module acumulador_digitos #(
    parameter int MAX_DIGITOS = 6,
    parameter int TIMEOUT_P   = 5000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               tecla_value,
    input  logic                     tecla_valid,
    output logic [4*MAX_DIGITOS-1:0] digitos,
    output logic [3:0]               num_digitos,
    output logic                     buffer_cheio,
    output logic [4*MAX_DIGITOS-1:0] senha,
    output logic [3:0]               senha_tam,
    output logic                     dado_valid,
    output logic                     timeout
);

    localparam int              c_DW   = 4 * MAX_DIGITOS;
    localparam int              c_CW   = $clog2(TIMEOUT_P);
    localparam logic [3:0]      c_MAX  = 4'(MAX_DIGITOS);
    localparam logic [c_CW-1:0] c_TLIM = c_CW'(TIMEOUT_P - 1);
    localparam logic [c_CW-1:0] c_UM   = c_CW'(1);

    localparam logic [3:0] c_TECLA_LIMPA = 4'hA;
    localparam logic [3:0] c_TECLA_APAGA = 4'hE;
    localparam logic [3:0] c_TECLA_ENTRA = 4'hF;

`ifdef ACUMULADOR_BACKSPACE_EN
    localparam logic c_BACKSPACE_EN = 1'b1;
`else
    localparam logic c_BACKSPACE_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        VAZIO  = 1'b0,
        COLETA = 1'b1
    } estado_t;

    estado_t           estado_q, estado_d;
    logic              armado_q;
    logic              tecla_valid_q;
    logic [c_DW-1:0]   digitos_q, digitos_d;
    logic [3:0]        num_q, num_d;
    logic [c_DW-1:0]   senha_q, senha_d;
    logic [3:0]        tam_q, tam_d;
    logic              dv_q, dv_d;
    logic              to_q, to_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;

    logic w_evento;
    logic w_eh_digito;
    logic w_aceita;
    logic w_vazio;
    logic w_cheio;

    // armado_q stays low for the first cycle after reset, so a key already
    // held across reset has to be released before it can register.
    assign w_evento    = tecla_valid & ~tecla_valid_q & armado_q;
    assign w_eh_digito = (tecla_value <= 4'd9);
    assign w_vazio     = (num_q == 4'd0);
    assign w_cheio     = (num_q == c_MAX);

    // Keys that act on the entry and therefore restart the idle counter.
    // 0xB..0xD (and 0xE without backspace) fall outside and let the
    // counter keep running.
    assign w_aceita = w_evento &
                      (w_eh_digito |
                       (tecla_value == c_TECLA_LIMPA) |
                       (tecla_value == c_TECLA_ENTRA) |
                       (c_BACKSPACE_EN & (tecla_value == c_TECLA_APAGA)));

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q      <= VAZIO;
            armado_q      <= 1'b0;
            tecla_valid_q <= 1'b0;
            digitos_q     <= '0;
            num_q         <= '0;
            senha_q       <= '0;
            tam_q         <= '0;
            dv_q          <= 1'b0;
            to_q          <= 1'b0;
            cnt_q         <= '0;
        end else begin
            estado_q      <= estado_d;
            armado_q      <= 1'b1;
            tecla_valid_q <= tecla_valid;
            digitos_q     <= digitos_d;
            num_q         <= num_d;
            senha_q       <= senha_d;
            tam_q         <= tam_d;
            dv_q          <= dv_d;
            to_q          <= to_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        digitos_d = digitos_q;
        num_d     = num_q;
        senha_d   = senha_q;
        tam_d     = tam_q;
        dv_d      = 1'b0;
        to_d      = 1'b0;
        // Counter only runs while an entry is being collected.
        cnt_d     = (estado_q == COLETA) ? (cnt_q + c_UM) : '0;

        // An accepted key has priority over a simultaneous timeout expiry.
        if (w_aceita) begin
            cnt_d = '0;
            if (w_eh_digito) begin
                // A digit on a full buffer is dropped but still restarts
                // the counter.
                if (!w_cheio) begin
                    digitos_d = c_DW'({digitos_q, tecla_value});
                    num_d     = num_q + 4'd1;
                    estado_d  = COLETA;
                end
            end else if (tecla_value == c_TECLA_LIMPA) begin
                digitos_d = '0;
                num_d     = '0;
                estado_d  = VAZIO;
            end else if (tecla_value == c_TECLA_APAGA) begin
                if (!w_vazio) begin
                    digitos_d = digitos_q >> 4;
                    num_d     = num_q - 4'd1;
                    if (num_q == 4'd1) begin
                        estado_d = VAZIO;
                    end
                end
            end else begin
                // Enter: closing an empty entry does nothing.
                if (!w_vazio) begin
                    senha_d   = digitos_q;
                    tam_d     = num_q;
                    dv_d      = 1'b1;
                    digitos_d = '0;
                    num_d     = '0;
                    estado_d  = VAZIO;
                end
            end
        end else if ((estado_q == COLETA) && (cnt_q == c_TLIM)) begin
            digitos_d = '0;
            num_d     = '0;
            to_d      = 1'b1;
            cnt_d     = '0;
            estado_d  = VAZIO;
        end
    end

    assign digitos      = digitos_q;
    assign num_digitos  = num_q;
    assign buffer_cheio = w_cheio;
    assign senha        = senha_q;
    assign senha_tam    = tam_q;
    assign dado_valid   = dv_q;
    assign timeout      = to_q;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_digitos.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acumulador_digitos
//  Purpose  : Directed self-checking bench for acumulador_digitos with
//             MAX_DIGITOS = 6 and TIMEOUT_P = 20.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acumulador_digitos;

    localparam int c_MAXD = 6;
    localparam int c_TP   = 20;

    logic                 clk;
    logic                 rst;
    logic [3:0]           tecla_value;
    logic                 tecla_valid;
    logic [4*c_MAXD-1:0]  digitos;
    logic [3:0]           num_digitos;
    logic                 buffer_cheio;
    logic [4*c_MAXD-1:0]  senha;
    logic [3:0]           senha_tam;
    logic                 dado_valid;
    logic                 timeout;

    int errors = 0;
    int checks = 0;

    acumulador_digitos #(
        .MAX_DIGITOS (c_MAXD),
        .TIMEOUT_P   (c_TP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_value  (tecla_value),
        .tecla_valid  (tecla_valid),
        .digitos      (digitos),
        .num_digitos  (num_digitos),
        .buffer_cheio (buffer_cheio),
        .senha        (senha),
        .senha_tam    (senha_tam),
        .dado_valid   (dado_valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        tecla_value = code;
        tecla_valid = 1'b1;
        repeat (hold) tick();
        tecla_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".digitos"},   32'(digitos),      32'h0);
        check({tag, ".num"},       32'(num_digitos),  32'h0);
        check({tag, ".cheio"},     32'(buffer_cheio), 32'h0);
        check({tag, ".senha"},     32'(senha),        32'h0);
        check({tag, ".tam"},       32'(senha_tam),    32'h0);
        check({tag, ".dv"},        32'(dado_valid),   32'h0);
        check({tag, ".timeout"},   32'(timeout),      32'h0);
    endtask

    initial begin
        // ---- reset, with a key held through and past reset ----
        rst         = 1'b1;
        tecla_value = 4'h5;
        tecla_valid = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick();
        check("held_through_reset.num", 32'(num_digitos), 32'h0);
        tecla_valid = 1'b0;
        repeat (2) tick();

        // ---- 1,2,3,# with latency checks ----
        tecla_value = 4'h1;
        tecla_valid = 1'b1;
        check("lat.before", 32'(num_digitos), 32'h0);
        tick();
        check("lat.after_num", 32'(num_digitos), 32'h1);
        check("lat.after_dig", 32'(digitos), 32'h1);
        repeat (2) tick();
        tecla_valid = 1'b0;
        repeat (2) tick();
        press(4'h2, 3, 2);
        press(4'h3, 3, 2);
        check("seq123.digitos", 32'(digitos), 32'h000123);
        check("seq123.num", 32'(num_digitos), 32'h3);
        tecla_value = 4'hF;
        tecla_valid = 1'b1;
        tick();
        check("enter.dv", 32'(dado_valid), 32'h1);
        check("enter.senha", 32'(senha), 32'h000123);
        check("enter.tam", 32'(senha_tam), 32'h3);
        check("enter.num", 32'(num_digitos), 32'h0);
        check("enter.digitos", 32'(digitos), 32'h0);
        tick();
        check("enter.dv_one_cycle", 32'(dado_valid), 32'h0);
        check("enter.senha_held", 32'(senha), 32'h000123);
        tick();
        tecla_valid = 1'b0;
        repeat (2) tick();

        // ---- 7 held 50 cycles: one digit, then timeout 20 cycles later ----
        tecla_value = 4'h7;
        tecla_valid = 1'b1;
        tick();
        check("hold7.num", 32'(num_digitos), 32'h1);
        check("hold7.digitos", 32'(digitos), 32'h7);
        repeat (19) tick();
        check("hold7.pre_to_num", 32'(num_digitos), 32'h1);
        check("hold7.pre_to_pulse", 32'(timeout), 32'h0);
        tick();
        check("hold7.to_pulse", 32'(timeout), 32'h1);
        check("hold7.to_num", 32'(num_digitos), 32'h0);
        check("hold7.to_dig", 32'(digitos), 32'h0);
        check("hold7.to_no_dv", 32'(dado_valid), 32'h0);
        tick();
        check("hold7.to_one_cycle", 32'(timeout), 32'h0);
        repeat (28) tick();
        check("hold7.no_retrigger", 32'(num_digitos), 32'h0);
        tecla_valid = 1'b0;
        repeat (2) tick();

        // ---- nine pressed eight times on a 6-digit buffer ----
        for (int i = 0; i < 8; i++) begin
            press(4'h9, 2, 1);
            if (i == 5) check("nines.cheio_at6", 32'(buffer_cheio), 32'h1);
        end
        check("nines.num", 32'(num_digitos), 32'h6);
        check("nines.cheio", 32'(buffer_cheio), 32'h1);
        check("nines.digitos", 32'(digitos), 32'h999999);
        press(4'hA, 1, 1);
        check("clear.digitos", 32'(digitos), 32'h0);
        check("clear.num", 32'(num_digitos), 32'h0);
        check("clear.cheio", 32'(buffer_cheio), 32'h0);
        check("clear.no_dv", 32'(dado_valid), 32'h0);

        // ---- ignored key 0xB does not restart the idle counter ----
        tecla_value = 4'h5;
        tecla_valid = 1'b1;
        tick();
        tecla_valid = 1'b0;
        repeat (4) tick();
        tecla_value = 4'hB;
        tecla_valid = 1'b1;
        tick();
        tecla_valid = 1'b0;
        check("keyB.digitos", 32'(digitos), 32'h5);
        repeat (14) tick();
        check("keyB.pre_to", 32'(timeout), 32'h0);
        tick();
        check("keyB.to_pulse", 32'(timeout), 32'h1);
        check("keyB.to_num", 32'(num_digitos), 32'h0);
        repeat (2) tick();

        // ---- key 4 lands exactly on the expiry cycle ----
        tecla_value = 4'h5;
        tecla_valid = 1'b1;
        tick();
        tecla_valid = 1'b0;
        repeat (19) tick();
        check("race.pre_num", 32'(num_digitos), 32'h1);
        tecla_value = 4'h4;
        tecla_valid = 1'b1;
        tick();
        tecla_valid = 1'b0;
        check("race.no_to", 32'(timeout), 32'h0);
        check("race.digitos", 32'(digitos), 32'h54);
        check("race.num", 32'(num_digitos), 32'h2);
        tick();
        check("race.no_to_next", 32'(timeout), 32'h0);
        press(4'hA, 1, 1);

        // ---- 8,6,* ----
        press(4'h8, 2, 1);
        press(4'h6, 2, 1);
        press(4'hE, 2, 1);
`ifdef ACUMULADOR_BACKSPACE_EN
        check("bksp.digitos", 32'(digitos), 32'h8);
        check("bksp.num", 32'(num_digitos), 32'h1);
`else
        check("bksp.digitos", 32'(digitos), 32'h86);
        check("bksp.num", 32'(num_digitos), 32'h2);
`endif
        press(4'hA, 1, 1);

        // ---- # on empty buffer, then reset mid-entry ----
        tecla_value = 4'hF;
        tecla_valid = 1'b1;
        tick();
        check("empty_enter.dv", 32'(dado_valid), 32'h0);
        check("empty_enter.senha", 32'(senha), 32'h000123);
        check("empty_enter.tam", 32'(senha_tam), 32'h3);
        tecla_valid = 1'b0;
        repeat (2) tick();
        press(4'h3, 2, 1);
        press(4'h3, 2, 1);
        check("mid.digitos", 32'(digitos), 32'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
